// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative right shifter (shift_right_iter).
//   shift_state_t   : FSM state encoding (idle / shifting / result ready)
//   FAST_STEP       : bit count of the wide step used by the fast build
//   SHAMT_W_DEFAULT : shift-amount width matching the 32-bit default operand
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    localparam int FAST_STEP       = 4;
    localparam int SHAMT_W_DEFAULT = 5;

endpackage : shift_pkg

// File: rtl/shift_right_step.sv
// ---------------------------------------------------------------------------
// shift_right_step
// Combinational single-step right shifter. Shifts the operand right by either
// 1 bit or FAST_STEP bits, filling vacated upper bits with fill_i.
// Ports:
//   data_i   in   WIDTH   operand
//   fill_i   in   1       bit shifted in at the top (0 for SRL, sign for SRA)
//   step4_i  in   1       1 = shift by FAST_STEP bits, 0 = shift by 1 bit
//   data_o   out  WIDTH   shifted operand
// ---------------------------------------------------------------------------
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    input  logic             step4_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] by1;
    logic [WIDTH-1:0] by4;

    assign by1    = {fill_i, data_i[WIDTH-1:1]};
    assign by4    = {{FAST_STEP{fill_i}}, data_i[WIDTH-1:FAST_STEP]};
    assign data_o = step4_i ? by4 : by1;

endmodule : shift_right_step

// File: rtl/shift_right_iter.sv
// ---------------------------------------------------------------------------
// shift_right_iter
// Multi-cycle right shifter for the MIPS execute stage (SRL/SRLV zero fill,
// SRA/SRAV sign fill). An accepted start loads the operand, fill bit and
// shift amount; the working register is then shifted each cycle until the
// amount is exhausted, and the result is presented with a one-cycle done.
//
// Build option: define SHIFT_RIGHT_FAST4_EN to shift FAST_STEP bits per cycle
// while at least FAST_STEP bits remain (1 bit otherwise). Without it the
// shifter moves exactly 1 bit per cycle. Results and handshake are identical.
//
// Ports:
//   clk       in   1        clock, rising edge
//   rst       in   1        synchronous active-high reset
//   start     in   1        request, accepted only while busy=0
//   in_data   in   WIDTH    operand, sampled on accept
//   shamt     in   SHAMT_W  shift amount, sampled on accept
//   arith     in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy      out  1        high from the cycle after accept through done
//   done      out  1        one-cycle pulse, out_data valid from this cycle
//   out_data  out  WIDTH    result, held until the next operation completes
// ---------------------------------------------------------------------------
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out_data
);

    shift_state_t       state_q, state_d;
    logic [SHAMT_W-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic               fill_q,  fill_d;
    logic [WIDTH-1:0]   out_q,   out_d;

    logic               step4;
    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] rem_dec;
    logic [WIDTH-1:0]   step_out;

`ifdef SHIFT_RIGHT_FAST4_EN
    assign step4 = (rem_q >= SHAMT_W'(FAST_STEP));
`else
    assign step4 = 1'b0;
`endif

    // step_amt never exceeds rem_q while shifting, so rem_dec cannot wrap.
    assign step_amt = step4 ? SHAMT_W'(FAST_STEP) : SHAMT_W'(1);
    assign rem_dec  = rem_q - step_amt;

    shift_right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i  (work_q),
        .fill_i  (fill_q),
        .step4_i (step4),
        .data_o  (step_out)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        fill_d  = fill_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = in_data;
                    fill_d = arith & in_data[WIDTH-1];
                    rem_d  = shamt;
                    if (shamt == '0) begin
                        // Zero shift: result is ready on the next cycle.
                        state_d = S_DONE;
                        out_d   = in_data;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_dec;
                // Load the result on the final step so it is valid with done.
                if (rem_dec == '0) begin
                    state_d = S_DONE;
                    out_d   = step_out;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    // Working operand and fill bit are only meaningful after an accept.
    always_ff @(posedge clk) begin
        work_q <= work_d;
        fill_q <= fill_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign out_data = out_q;

endmodule : shift_right_iter

// File: tb/tb_shift_right_iter.sv
module tb_shift_right_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  in_data;
    logic [4:0]    shamt;
    logic          arith;
    logic          busy;
    logic          done;
    logic [W-1:0]  out_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        int           lat;
    } exp_t;

    exp_t sb[$];

    shift_right_iter #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .shamt    (shamt),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic a);
        logic signed [W-1:0] sd;
        sd = d;
        if (a) return W'(sd >>> s);
        return d >> s;
    endfunction

    function automatic int exp_lat(input int s);
`ifdef SHIFT_RIGHT_FAST4_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Drive one request, push its expectation, and wait (bounded) for done.
    // Returns at #1 after the edge that raised done; lat counts cycles from accept.
    task automatic run_op(input logic [W-1:0] d, input int s, input logic a,
                          output logic [W-1:0] got, output int lat,
                          output bit busy_ok, output bit hold_ok);
        logic [W-1:0] prev;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(posedge clk); #1;
        prev    = out_data;
        in_data = d;
        shamt   = 5'(s);
        arith   = a;
        start   = 1'b1;
        sb.push_back('{model(d, s, a), exp_lat(s)});
        @(posedge clk); #1;
        start   = 1'b0;
        in_data = $urandom;
        arith   = ~a;
        lat = 1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (out_data !== prev) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        got = out_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_data = '0; shamt = '0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=0", out_data); end
        rst = 1'b0;
    endtask

    task automatic test_srl_sra();
        logic [W-1:0] got; int lat; bit bok, hok; exp_t e;
        run_op(32'h8000_0000, 4, 1'b0, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'h0800_0000 || got !== e.data) begin n_err++; $display("FAIL srl_data got=%h exp=08000000", got); end
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL srl_latency got=%0d exp=%0d", lat, e.lat); end
        run_op(32'h8000_0000, 4, 1'b1, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'hF800_0000 || got !== e.data) begin n_err++; $display("FAIL sra_data got=%h exp=f8000000", got); end
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL sra_latency got=%0d exp=%0d", lat, e.lat); end
        n_cmp++; if (!bok) begin n_err++; $display("FAIL sra_busy got=low_during_op exp=high"); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL sra_after_done got=busy%b/done%b exp=0/0", busy, done); end
    endtask

    task automatic test_zero_shift();
        logic [W-1:0] got; int lat; bit bok, hok; exp_t e;
        run_op(32'hDEAD_BEEF, 0, 1'b1, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL zero_data got=%h exp=deadbeef", got); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        n_cmp++; if (!bok) begin n_err++; $display("FAIL zero_busy got=low exp=high"); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL zero_after got=busy%b/done%b exp=0/0", busy, done); end
    endtask

    task automatic test_max_and_ignore();
        int lat; int extra_done; exp_t e;
        @(posedge clk); #1;
        in_data = 32'h8000_0000; shamt = 5'd31; arith = 1'b1; start = 1'b1;
        sb.push_back('{model(32'h8000_0000, 31, 1'b1), exp_lat(31)});
        @(posedge clk); #1;                 // accept edge T
        start = 1'b0; arith = 1'b0; in_data = 32'h0;
        lat = 1;
        while (!done && lat < 200) begin
            if (lat == 3) begin
                in_data = 32'h1234_5678; shamt = 5'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (out_data !== 32'hFFFF_FFFF || out_data !== e.data) begin n_err++; $display("FAIL max_data got=%h exp=ffffffff", out_data); end
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL max_latency got=%0d exp=%0d", lat, e.lat); end
        extra_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        n_cmp++; if (extra_done != 0) begin n_err++; $display("FAIL ignored_start got=%0d_active_cycles exp=0", extra_done); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] got; int lat; bit bok, hok; int seen; exp_t e;
        @(posedge clk); #1;
        in_data = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;                 // accept edge T
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;                 // reset sampled at T+3
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", done); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL abort_out got=%h exp=0", out_data); end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        run_op(32'h0000_00F0, 4, 1'b0, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'h0000_000F || got !== e.data) begin n_err++; $display("FAIL post_abort_data got=%h exp=0000000f", got); end
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got; int lat; bit bok, hok; exp_t e;
        run_op(32'h0000_0080, 2, 1'b0, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'h0000_0020) begin n_err++; $display("FAIL b2b_first got=%h exp=00000020", got); end
        // run_op asserts start during the cycle right after done.
        run_op(32'h0000_0100, 8, 1'b0, got, lat, bok, hok);
        e = sb.pop_front();
        n_cmp++; if (got !== 32'h0000_0001 || got !== e.data) begin n_err++; $display("FAIL b2b_second got=%h exp=00000001", got); end
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, e.lat); end
        n_cmp++; if (!hok) begin n_err++; $display("FAIL b2b_hold got=changed_before_done exp=held"); end
    endtask

    task automatic test_random();
        logic [W-1:0] got; int lat; bit bok, hok; exp_t e;
        logic [W-1:0] d; int s; logic a;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            d[W-1] = i[0];
            s = $urandom_range(0, 31);
            a = i[1];
            run_op(d, s, a, got, lat, bok, hok);
            e = sb.pop_front();
            n_cmp++; if (got !== e.data) begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got, e.data); end
            n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            n_cmp++; if (!bok || !hok) begin n_err++; $display("FAIL rand_handshake[%0d] got=busy_ok%0b/hold_ok%0b exp=1/1", i, bok, hok); end
        end
    endtask

    initial begin
        test_reset();
        test_srl_sra();
        test_zero_shift();
        test_max_and_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_shift_right_iter
